// File: rtl/param_shift_counter.sv
// -----------------------------------------------------------------------------
// param_shift_counter
//
// Purpose:
//   Generic WIDTH-bit shift-register sequence generator. It runs as a ring
//   counter (one-hot style, period WIDTH) or as a Johnson counter (twisted
//   ring, period 2*WIDTH). The mode is captured at load time. Each enabled
//   edge shifts one step toward the MSB or the LSB, chosen per edge by dir.
//   A step index and a one-cycle wrap pulse let downstream logic find the
//   slot boundaries without decoding q.
//
// Optional build feature:
//   PARAM_SHIFT_COUNTER_SELF_CORRECT_EN
//     When defined, every enabled edge first checks that q is a legal state
//     for the current mode. An illegal state is replaced by RESET_VAL, idx
//     is cleared and err pulses for one cycle. No shift happens on that edge.
//     When undefined, no checking is done and err is always 0.
//
// Parameters:
//   WIDTH      counter width in bits, 2..32
//   RESET_VAL  pattern on q after reset and after self-correction
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   en        in   shift enable, one step per enabled edge
//   load      in   synchronous load of load_val and mode (wins over en)
//   load_val  in   [WIDTH]  pattern loaded into q
//   mode      in   0 = ring, 1 = Johnson; sampled only while load=1
//   dir       in   0 = shift toward MSB, 1 = shift toward LSB
//   q         out  [WIDTH]  counter state
//   idx       out  [$clog2(2*WIDTH)]  steps since last load/reset, mod period
//   wrap      out  one-cycle pulse on the edge that completes a period
//   err       out  one-cycle pulse on self-correction
// -----------------------------------------------------------------------------
module param_shift_counter #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [WIDTH-1:0]              load_val,
    input  logic                          mode,
    input  logic                          dir,
    output logic [WIDTH-1:0]              q,
    output logic [$clog2(2*WIDTH)-1:0]    idx,
    output logic                          wrap,
    output logic                          err
);

    localparam int unsigned IDX_W = $clog2(2 * WIDTH);

    // Last index of each period. The Johnson period 2*WIDTH may equal
    // 2**IDX_W, so only P-1 is stored. It always fits in IDX_W bits.
    localparam logic [IDX_W-1:0] LAST_RING    = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_JOHNSON = IDX_W'(2 * WIDTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] q_q,    q_d;
    logic [IDX_W-1:0] idx_q,  idx_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             err_q,  err_d;

    logic [IDX_W-1:0] last_idx;
    logic             illegal;

    // -------------------------------------------------------------------------
    // One shift step.
    // The bit that enters at the far end is the bit that leaves, or its
    // inverse in Johnson mode. That inversion is the only difference between
    // the two modes, and it doubles the period.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic             johnson,
        input logic             toward_lsb
    );
        logic fb;
        if (!toward_lsb) begin
            fb         = johnson ? ~v[WIDTH-1] : v[WIDTH-1];
            shift_step = {v[WIDTH-2:0], fb};
        end else begin
            fb         = johnson ? ~v[0] : v[0];
            shift_step = {fb, v[WIDTH-1:1]};
        end
    endfunction

`ifdef PARAM_SHIFT_COUNTER_SELF_CORRECT_EN
    // A legal ring state has exactly one bit set.
    function automatic logic ring_legal(input logic [WIDTH-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones += int'(v[i]);
        end
        ring_legal = (ones == 1);
    endfunction

    // A legal Johnson state is a run of ones against a run of zeros. Inside
    // the linear bit chain there is at most one boundary between the runs.
    // The wrap-around pair is not counted, because the Johnson feedback
    // inverts that bit.
    function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
        int unsigned edges;
        edges = 0;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            edges += int'(v[i] ^ v[i+1]);
        end
        johnson_legal = (edges <= 1);
    endfunction

    assign illegal = mode_q ? !johnson_legal(q_q) : !ring_legal(q_q);
`else
    assign illegal = 1'b0;
`endif

    assign last_idx = mode_q ? LAST_JOHNSON : LAST_RING;

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: load, then en, then hold.
    // Reset is applied in the register process.
    // -------------------------------------------------------------------------
    always_comb begin
        q_d    = q_q;
        idx_d  = idx_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;

        if (load) begin
            // The loaded pattern is not checked here. Any check happens on
            // the next enabled edge.
            q_d    = load_val;
            mode_d = mode;
            idx_d  = '0;
        end else if (en) begin
            if (illegal) begin
                q_d   = RESET_VAL;
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                q_d = shift_step(q_q, mode_q, dir);
                // idx counts steps in either direction. It measures progress
                // through the period, not position in the pattern.
                if (idx_q == last_idx) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            idx_q  <= '0;
            mode_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            idx_q  <= idx_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q    = q_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: doc/param_shift_counter.md
Name: param_shift_counter

Overview:
- Parametrised successor to the team's fixed 4-bit loadable ring counter.
- Generalised to WIDTH bits, with a run-time mode (ring / Johnson), a run-time direction, a count enable, a step-index output and a wrap pulse.
- Used as a sequence/phase generator for one-hot strobes and timing slots in the challenge designs.

Parameters:
WIDTH, 4, counter width in bits; legal range 2 to 32.
RESET_VAL, 1, pattern driven on q at reset and after self-correction; must be WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  shift enable; one step per enabled edge
load  input  1  synchronous load of load_val and mode
load_val  input  WIDTH  pattern loaded into q
mode  input  1  0 = ring, 1 = Johnson; sampled only when load=1
dir  input  1  0 = shift toward MSB, 1 = shift toward LSB; sampled every enabled edge
q  output  WIDTH  counter state
idx  output  $clog2(2*WIDTH)  steps taken since last load/reset, modulo period
wrap  output  1  one-cycle pulse on the edge that completes a full period
err  output  1  one-cycle pulse on self-correction (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. On reset: q=RESET_VAL, idx=0, wrap=0, err=0, internal mode_q=0 (ring).
- Priority on each rising edge: rst, then load, then en, then hold.

Load:
- q<=load_val, mode_q<=mode, idx<=0, wrap<=0.
- The loaded pattern is not validated at load time.

Shift (en=1, load=0):
- Ring, dir=0: q<={q[W-2:0],q[W-1]}.
- Ring, dir=1: q<={q[0],q[W-1:1]}.
- Johnson, dir=0: q<={q[W-2:0],~q[W-1]}.
- Johnson, dir=1: q<={~q[0],q[W-1:1]}.
- Period P = WIDTH in ring mode, 2*WIDTH in Johnson mode.
- idx increments by 1 on every shift regardless of dir. When idx=P-1, idx<=0 and wrap<=1 on the same edge.

Hold (en=0, load=0):
- q, idx and mode_q hold; wrap<=0, err<=0.

Output timing:
- wrap and err are registered and high for exactly one cycle.
- Latency is one edge from en/load to the q change.
- dir may change on any cycle; it affects only the next shift and does not reset idx.
- mode changes take effect only through load.

Boundary cases:
- An all-zero pattern in ring mode is legal without the macro and stays zero forever while idx still advances.
- WIDTH=2 in Johnson mode: P=4, idx is 2 bits.
- Reset asserted mid-shift overrides everything immediately, without waiting for a clock edge.

Optional Feature:
Macro: PARAM_SHIFT_COUNTER_SELF_CORRECT_EN

With the macro defined, on an enabled edge the current q is checked instead of being shifted:
- Ring mode: q is illegal if its popcount is not 1.
- Johnson mode: q is illegal if more than one i in 0..W-2 has q[i]!=q[i+1].
- If q is illegal: q<=RESET_VAL, idx<=0, err<=1 for one cycle, no shift, wrap=0.
- Legal states shift normally. Correction takes effect only on enabled edges; load still has priority.

Without the macro:
- No checking is done; err is tied to 0.
- Illegal patterns shift as normal ring/Johnson data.

Test Plan:
1. Reset. WIDTH=4, assert rst between edges -> q=0001, idx=0, wrap=0, err=0 immediately, without waiting for an edge.
2. Ring left. Load 0100 with mode=0, then 4 enabled edges with dir=0 -> q = 1000, 0001, 0010, 0100; idx = 1, 2, 3, 0; wrap=1 only after the 4th edge. Then dir=1 from 0100 -> 0010.
3. Johnson. Load 0000 with mode=1, then 8 edges with dir=0 -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap=1 only after the 8th edge, idx=0.
4. Priority and hold. load=1 and en=1 with load_val=1000 -> q=1000, idx=0, no shift. en=0 for 3 cycles -> q, idx hold, wrap=0. rst asserted mid-sequence at q=0010 -> q=0001 at once.
5. Self-correct. Load 0110 with mode=0, then one enabled edge:
   - With macro: q=0001, idx=0, err=1 for one cycle.
   - Without macro: q=1100, err=0.
   - Johnson check: load 0101 with mode=1, with macro -> corrected to 0001 with err pulse.
